ram_bank: RTL and testbench
===========================

// Module: ram_bank
// PURPOSE
//  Parametrised successor of the single 16-bit load register: a bank of DEPTH
//  words of WIDTH bits each, with one addressed write port and one addressed read port.
//  Adds a built-in clear sequencer that zeroes every word, one word per cycle.
//  Serves as the data-memory building block (RAM8/RAM64 class) for the CPU datapath.
// PARAMETERS
//  WIDTH   16  word width in bits; data is two's-complement signed
//  ADDR_W  3   address width; DEPTH = 2**ADDR_W words
// PORTS
//  clk      in   1       clock; all state changes on the rising edge
//  rst_n    in   1       asynchronous, active-low reset
//  in       in   WIDTH   write data (signed)
//  load     in   1       write enable for mem[address]
//  address  in   ADDR_W  write and read address
//  clear    in   1       request to zero all words (single-cycle pulse or level)
//  out      out  WIDTH   mem[address], combinational read (signed)
//  busy     out  1       high while the clear sweep is running
// BEHAVIOUR
//  Reset (rst_n=0, any time, including mid-sweep):
//   - all words = 0; state = IDLE; sweep pointer = 0
//   - out = 0 and busy = 0 immediately, without waiting for a clock edge
//  Read port:
//   - out = mem[address] with no clock; an address change shows the new word at once
//  Write in IDLE:
//   - load=1 at an edge: mem[address] <= in
//   - the new value appears on out after that edge: out(t+1) = in(t)
//   - load=0: contents hold; in is ignored
//  State machine, 2 states:
//   - IDLE: on an edge with clear=1, go to CLEAR with ptr <= 0. No word is written on
//     that edge: clear has priority over load.
//   - CLEAR: on each edge, mem[ptr] <= 0 and ptr <= ptr+1.
//     The edge that writes ptr = DEPTH-1 returns to IDLE; ptr wraps to 0.
//   - Sweep length is exactly DEPTH edges.
//   - busy = (state == CLEAR). It rises after the clear edge and falls after the last sweep edge.
//  During CLEAR:
//   - load is ignored and no write occurs
//   - clear is ignored; the sweep does not restart
//   - out reads normally: a word not yet swept shows its old value; a swept word shows 0
//  Edge cases:
//   - load with DEPTH-1 as address: no wrap or alias, each address is independent
//   - WIDTH bits are stored verbatim: -32768 and 32767 round-trip unchanged
//   - clear held high continuously: one sweep, back to IDLE, then a new sweep starts on the
//     next edge, because clear is re-sampled in IDLE
//   - rst_n is deasserted asynchronously. The first edge after release behaves as IDLE.
// TESTING
//  1 Reset then read: rst_n=0, then release; sweep address 0..7 -> out=0 for every
//    address, busy=0.
//  2 Write/hold:
//    - load=1, address=5, in=-32123 at one edge
//    - then load=0, in=11111 for 2 edges
//    -> out at address 5 = -32123; at address 4, out=0
//  3 Full-range data:
//    - write 1,2,4,...,16384,-32768 and 32767 across the addresses, one per edge
//    - read each word back -> exact match; neighbouring words are undisturbed
//  4 Clear sweep:
//    - fill all 8 words with 12345
//    - pulse clear together with load=1, address=0, in=7
//    -> busy=1 for exactly 8 cycles
//    -> address 0 never reads 7
//    -> after the sweep, every word reads 0
//  5 Ignored inputs during sweep:
//    - at sweep cycle 3: load=1, address=7, in=-2
//    - at sweep cycle 4: clear=1
//    -> word 7 = 0 after the sweep; busy falls after 8 cycles total
//  6 Reset mid-sweep:
//    - start a sweep; assert rst_n=0 at sweep cycle 4, between clock edges
//    -> busy=0 and out=0 immediately
//    -> after release, a load to address 6 with in=-9 reads back -9

Source files
------------

// File: rtl/ram_bank.sv
// ram_bank: a bank of 2**ADDR_W signed words with one addressed write port and a
// combinational read port. It also has a clear sequencer that zeroes one word per cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; zeroes every word and returns to idle
//   in       write data (signed)
//   load     write enable for mem[address] (idle only)
//   address  shared write/read address
//   clear    starts a full clear sweep (sampled in idle only; wins over load)
//   out      mem[address], combinational
//   busy     high while the clear sweep runs

module ram_bank #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [WIDTH-1:0]  in,
  input  logic                     load,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     clear,
  output logic signed [WIDTH-1:0]  out,
  output logic                     busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we      = 1'b0;
    waddr   = address;
    wdata   = in;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          // The clear edge writes nothing, even with load asserted.
          state_d = StClear;
          ptr_d   = '0;
        end else if (load) begin
          we = 1'b1;
        end
      end
      StClear: begin
        // load and clear are both ignored until the sweep completes.
        we    = 1'b1;
        waddr = ptr_q;
        wdata = '0;
        ptr_d = ptr_q + 1'b1;  // wraps to 0 after the last word
        if (ptr_q == LastAddr) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign out  = mem_q[address];
  assign busy = (state_q == StClear);

endmodule

// File: tb/tb_ram_bank.sv
`timescale 1ns/1ps
module tb_ram_bank;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] in;
  logic               load;
  logic [2:0]         address;
  logic               clear;
  logic signed [15:0] out;
  logic               busy;

  int n_pass;
  int n_checks;

  // Reference model: contents plus the number of sweep edges still owed.
  logic signed [15:0] model [8];
  int                 sweep_left;

  ram_bank #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = '0;
    sweep_left = 0;
  endtask

  // One clock edge as seen by the specification.
  task automatic model_edge(input logic ld, input logic cl, input logic [2:0] a,
                            input logic signed [15:0] d);
    if (sweep_left > 0) begin
      model[8 - sweep_left] = '0;
      sweep_left--;
    end else if (cl) begin
      sweep_left = 8;
    end else if (ld) begin
      model[a] = d;
    end
  endtask

  // Drive inputs, take one edge, update the model, settle 1ns past the edge.
  task automatic cycle(input logic ld, input logic cl, input logic [2:0] a,
                       input logic signed [15:0] d);
    load = ld; clear = cl; address = a; in = d;
    @(posedge clk);
    model_edge(ld, cl, a, d);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; load = 0; clear = 0; address = 0; in = 0;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      n_checks++;
      if (out !== 16'sd0) $display("FAIL reset_word[%0d]: got %0d want 0", a, out);
      else n_pass++;
    end
  endtask

  task automatic test_write_hold();
    cycle(1, 0, 5, -16'sd32123);
    cycle(0, 0, 5, 16'sd11111);
    cycle(0, 0, 5, 16'sd11111);
    n_checks++;
    if (out !== -16'sd32123) $display("FAIL hold_addr5: got %0d want -32123", out);
    else n_pass++;
    address = 4;
    #1;
    n_checks++;
    if (out !== 16'sd0) $display("FAIL hold_addr4: got %0d want 0", out);
    else n_pass++;
  endtask

  task automatic test_full_range();
    logic signed [15:0] vals [17];
    for (int i = 0; i < 15; i++) vals[i] = 16'(1 << i);
    vals[15] = -16'sd32768;
    vals[16] = 16'sd32767;
    for (int i = 0; i < 17; i++) begin
      cycle(1, 0, 3'(i), vals[i]);
      load = 0;
      n_checks++;
      if (out !== vals[i]) $display("FAIL range_word[%0d]: got %0d want %0d", i % 8, out, vals[i]);
      else n_pass++;
      address = 3'(i + 1);
      #1;
      n_checks++;
      if (out !== model[3'(i + 1)])
        $display("FAIL range_neighbour[%0d]: got %0d want %0d", (i + 1) % 8, out, model[3'(i + 1)]);
      else n_pass++;
    end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      n_checks++;
      if (out !== model[a]) $display("FAIL range_read[%0d]: got %0d want %0d", a, out, model[a]);
      else n_pass++;
    end
  endtask

  task automatic test_clear_sweep();
    int busy_cycles;
    int saw7;
    for (int a = 0; a < 8; a++) cycle(1, 0, 3'(a), 16'sd12345);
    cycle(1, 1, 0, 16'sd7);
    busy_cycles = 0;
    saw7 = 0;
    for (int k = 0; k < 20 && busy === 1'b1; k++) begin
      busy_cycles++;
      if (out === 16'sd7) saw7++;
      cycle(0, 0, 0, 16'sd0);
    end
    if (out === 16'sd7) saw7++;
    n_checks++;
    if (busy_cycles != 8) $display("FAIL sweep_busy_len: got %0d want 8", busy_cycles);
    else n_pass++;
    n_checks++;
    if (saw7 != 0) $display("FAIL sweep_no_write: addr0 read 7 in %0d cycles, want 0", saw7);
    else n_pass++;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      n_checks++;
      if (out !== 16'sd0) $display("FAIL sweep_zero[%0d]: got %0d want 0", a, out);
      else n_pass++;
    end
  endtask

  task automatic test_ignored_during_sweep();
    cycle(1, 0, 7, 16'sd100);
    cycle(0, 1, 7, 16'sd0);
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (busy !== 1'b1) $display("FAIL ign_busy_cycle%0d: got %b want 1", k, busy);
      else n_pass++;
      n_checks++;
      if (out !== model[7]) $display("FAIL ign_word7_cycle%0d: got %0d want %0d", k, out, model[7]);
      else n_pass++;
      if (k == 3)      cycle(1, 0, 7, -16'sd2);
      else if (k == 4) cycle(0, 1, 7, 16'sd0);
      else             cycle(0, 0, 7, 16'sd0);
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL ign_busy_end: got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (out !== 16'sd0) $display("FAIL ign_word7_end: got %0d want 0", out);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    cycle(1, 0, 6, 16'sd55);
    cycle(0, 1, 6, 16'sd0);
    repeat (4) cycle(0, 0, 6, 16'sd0);
    n_checks++;
    if (out !== 16'sd55 || busy !== 1'b1)
      $display("FAIL midrst_before: got out=%0d busy=%b want out=55 busy=1", out, busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (out !== 16'sd0) $display("FAIL midrst_out: got %0d want 0", out);
    else n_pass++;
    #1 rst_n = 1'b1;
    cycle(1, 0, 6, -16'sd9);
    load = 0;
    n_checks++;
    if (out !== -16'sd9 || busy !== 1'b0)
      $display("FAIL midrst_load: got out=%0d busy=%b want out=-9 busy=0", out, busy);
    else n_pass++;
  endtask

  task automatic test_random();
    logic               ld, cl;
    logic [2:0]         a;
    logic signed [15:0] d;
    int                 errs;
    errs = 0;
    for (int k = 0; k < 400; k++) begin
      ld = 1'($urandom_range(0, 1));
      cl = ($urandom_range(0, 24) == 0);
      a  = 3'($urandom_range(0, 7));
      d  = 16'($urandom);
      cycle(ld, cl, a, d);
      n_checks++;
      if (out !== model[a] || busy !== (sweep_left > 0)) begin
        if (errs < 10)
          $display("FAIL random_step%0d: got out=%0d busy=%b want out=%0d busy=%b",
                   k, out, busy, model[a], sweep_left > 0);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_checks = 0;
    test_reset();
    test_write_hold();
    test_full_range();
    test_clear_sweep();
    test_ignored_during_sweep();
    test_reset_mid_sweep();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
